ar_rd_req_mapper: RTL and testbench
===================================

Name: ar_rd_req_mapper

Overview:
- Sits directly downstream of the AR pop FSM, between the popped AR FIFO entry and the PCIe TX arbiter.
- Captures one AR entry when the pop FSM offers it, then splits the burst into one or more PCIe Memory Read (MRd) TLP headers. Splits fall on Max_Read_Request_Size boundaries, which also guarantees no 4 KB crossing.
- Presents each header to the arbiter with a valid/grant handshake.
- After the last segment is granted, returns the single-cycle grant that retires the entry in the pop FSM.

Parameters:
- REQUESTER_ID, 16'h0100, Bus/Dev/Fn placed in header DW1.
- MRRS_BYTES, 512, Max read request size in bytes; power of two, 128..4096.
- TAG_WIDTH, 8, width of the free-running tag counter.
- ID_WIDTH, $clog2(ARFIFO_DEPTH), width of the AR ID.

Ports:
- CLK  in  1  clock.
- ARESTn  in  1  asynchronous active-low reset.
- rd_atop_en  in  1  pop FSM offering an entry; held high until pop grant.
- ar_addr  in  ADDR_WIDTH(64)  ARADDR of the offered entry.
- ar_len  in  8  ARLEN (beats-1).
- ar_size  in  AxSIZE_WIDTH(3)  ARSIZE.
- ar_burst  in  AxBURST_WIDTH(2)  ARBURST.
- ar_id  in  ID_WIDTH  ARID.
- ar_user  in  ARUSER_WIDTH  ARUSER.
- axi_req_rd_grant  out  1  pulse to pop FSM: entry fully issued.
- tlp_rd_req  out  1  header valid toward arbiter.
- arb_rd_grant  in  1  arbiter accepts the current header.
- tlp_hdr  out  128  MRd header DW0..DW3 (DW3 is don't-care for 3DW).
- tlp_tag  out  TAG_WIDTH  tag of the current header.
- trk_id  out  ID_WIDTH  ARID, for the completion tracker.
- trk_last  out  1  current header is the last segment of the entry.
- trk_seg_bytes  out  13  byte count of the current segment.

Behaviour:
- Reset values:
  - All outputs are 0.
  - FSM is in IDLE and the tag counter is 0.
  - A reset mid-operation abandons the entry; no pop grant is emitted.
- States: IDLE, CAPTURE, CALC, REQ, LOCAL.
- IDLE:
  - On rd_atop_en=1, register all ar_* fields and go to CAPTURE.
  - rd_atop_en is ignored in every other state.
- CAPTURE:
  - If ar_user[2:0]==3'b011 (locally completed entry), go to LOCAL.
  - Otherwise:
    - remaining = (ar_len+1) << ar_size (16 bits; FIXED counts as (1<<ar_size)).
    - cur_addr = ar_addr; for WRAP, cur_addr = ar_addr aligned down to the wrap container size remaining.
    - Go to CALC.
- LOCAL: pulse axi_req_rd_grant for 1 cycle, issue no TLP, go to IDLE.
- CALC (one cycle):
  - seg = min(remaining, MRRS_BYTES - cur_addr mod MRRS_BYTES).
  - len_dw = ceil((cur_addr[1:0]+seg)/4); a value of 1024 encodes as 0.
  - Register the header, then go to REQ.
- Header fields:
  - Fmt = 3'b000 if cur_addr[63:32]==0 (3DW), else 3'b001 (4DW); Type = 5'b00000.
  - TC = 0, Attr = 0, TD = 0, EP = 0, Length = len_dw.
  - DW1 = {REQUESTER_ID, tag, LastBE, FirstBE}.
  - 3DW address is {cur_addr[31:2],2'b00} in DW2; 4DW address is upper DW2, lower DW3.
- Byte enables:
  - FirstBE = 4'hF << cur_addr[1:0].
  - LastBE = 4'hF >> (3 - end_addr[1:0]), where end_addr = cur_addr+seg-1.
  - If len_dw==1: FirstBE &= LastBE' (the LastBE computation applied to the same DW), and LastBE = 0.
- REQ:
  - tlp_rd_req=1; all header and trk_* outputs stay stable until arb_rd_grant.
  - On grant: tag++ (wraps mod 2^TAG_WIDTH), remaining -= seg, cur_addr += seg.
  - If remaining becomes 0: pulse axi_req_rd_grant in the grant cycle (same edge), then go to IDLE.
  - Otherwise go to CALC; tlp_rd_req drops for that one cycle.
- The minimum entry-to-first-request latency is 3 cycles (CAPTURE, CALC, REQ).
- Only one entry is in flight at a time.

Decomposition:
- axi_slave_package gains:
  - typedef enum rd_map_state_e {IDLE, CAPTURE, CALC, REQ, LOCAL};
  - MRD_FMT_3DW/4DW and MRD_TYPE constants;
  - function first_last_be().
- One sub-module, mrd_seg_calc: a combinational segment size / len_dw / BE calculation, instantiated in CALC.

Test Plan:
1. addr=0x1000, len=3, size=2, INCR, user=0 → one 3DW TLP: Length=4, FirstBE=F, LastBE=F, tag=0, trk_last=1. Pop grant in the same cycle as arb grant.
2. addr=0x1FC, len=1, size=3, MRRS=512 → two TLPs:
   - 0x1FC, Length=1, FirstBE=F, LastBE=0;
   - 0x200, Length=3, FirstBE=F, LastBE=F, trk_seg_bytes=12.
   - Single pop grant, after the second TLP.
3. addr=0x1_0000_0002, len=0, size=0 → 4DW (Fmt=001): DW2=0x00000001, DW3=0x00000000, Length=1, FirstBE=4'b0100, LastBE=0.
4. addr=0, len=255, size=3, MRRS=512 → 4 TLPs of Length=128 at 0x000/0x200/0x400/0x600, tags 0..3. trk_last only on the 4th.
5. user[2:0]=3'b011 → no tlp_rd_req; axi_req_rd_grant pulses 2 cycles after rd_atop_en.
6. Hold arb_rd_grant=0 for 10 cycles in REQ → tlp_rd_req and tlp_hdr are stable. Drop ARESTn mid-burst → all outputs 0 and FSM in IDLE.

Source files
------------

// File: rtl/ar_rd_req_mapper_pkg.sv
// Shared types and constants for the AR read-request mapper: FSM state
// encoding, MRd header constants and the byte-enable helper.
package ar_rd_req_mapper_pkg;

  localparam int ADDR_WIDTH       = 64;
  localparam int AXSIZE_WIDTH     = 3;
  localparam int AXBURST_WIDTH    = 2;
  localparam int ARFIFO_DEPTH     = 16;
  localparam int DEF_ID_WIDTH     = $clog2(ARFIFO_DEPTH);
  localparam int DEF_TAG_WIDTH    = 8;
  localparam int DEF_ARUSER_WIDTH = 4;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  // ar_user[2:0] marking an entry that completes locally (no TLP needed)
  localparam logic [2:0] USER_LOCAL = 3'b011;

  localparam logic [2:0] MRD_FMT_3DW = 3'b000;
  localparam logic [2:0] MRD_FMT_4DW = 3'b001;
  localparam logic [4:0] MRD_TYPE    = 5'b00000;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    CALC    = 3'd2,
    REQ     = 3'd3,
    LOCAL   = 3'd4
  } rd_map_state_e;

  // Returns {LastBE, FirstBE}. A single-DW request folds the end mask into
  // FirstBE and leaves LastBE at zero, as PCIe requires.
  function automatic logic [7:0] first_last_be(input logic [1:0] start_off,
                                               input logic [1:0] end_off,
                                               input logic       single_dw);
    logic [3:0] fbe;
    logic [3:0] lbe;
    fbe = 4'hF << start_off;
    lbe = 4'hF >> (2'd3 - end_off);
    if (single_dw) begin
      fbe = fbe & lbe;
      lbe = 4'h0;
    end
    return {lbe, fbe};
  endfunction

endpackage

// File: rtl/ar_rd_req_mapper_if.sv
// Bundle between the AR pop FSM / PCIe TX arbiter and the read-request mapper.
//
// Handshakes:
//   rd_atop_en is a level held by the pop FSM (with all ar_* fields stable)
//   until the mapper answers with a single-cycle axi_req_rd_grant.
//   tlp_rd_req/arb_rd_grant: a header is transferred on a cycle where both
//   are high; while tlp_rd_req is high and arb_rd_grant is low, tlp_hdr,
//   tlp_tag and trk_* are held stable.
interface ar_rd_req_mapper_if #(
  parameter int ID_WIDTH     = ar_rd_req_mapper_pkg::DEF_ID_WIDTH,
  parameter int TAG_WIDTH    = ar_rd_req_mapper_pkg::DEF_TAG_WIDTH,
  parameter int ARUSER_WIDTH = ar_rd_req_mapper_pkg::DEF_ARUSER_WIDTH
);
  logic                    rd_atop_en;
  logic [63:0]             ar_addr;
  logic [7:0]              ar_len;
  logic [2:0]              ar_size;
  logic [1:0]              ar_burst;
  logic [ID_WIDTH-1:0]     ar_id;
  logic [ARUSER_WIDTH-1:0] ar_user;
  logic                    axi_req_rd_grant;
  logic                    tlp_rd_req;
  logic                    arb_rd_grant;
  logic [127:0]            tlp_hdr;
  logic [TAG_WIDTH-1:0]    tlp_tag;
  logic [ID_WIDTH-1:0]     trk_id;
  logic                    trk_last;
  logic [12:0]             trk_seg_bytes;

  // The mapper itself
  modport slave (
    input  rd_atop_en, ar_addr, ar_len, ar_size, ar_burst, ar_id, ar_user,
    input  arb_rd_grant,
    output axi_req_rd_grant, tlp_rd_req, tlp_hdr, tlp_tag,
    output trk_id, trk_last, trk_seg_bytes
  );

  // Environment: pop FSM plus arbiter
  modport master (
    output rd_atop_en, ar_addr, ar_len, ar_size, ar_burst, ar_id, ar_user,
    output arb_rd_grant,
    input  axi_req_rd_grant, tlp_rd_req, tlp_hdr, tlp_tag,
    input  trk_id, trk_last, trk_seg_bytes
  );
endinterface

// File: rtl/ar_rd_req_mapper_mrd_seg_calc.sv
// Combinational sizing of the next MRd segment: byte count limited by the
// remaining burst and the next MRRS boundary, DW length and byte enables.
module mrd_seg_calc
  import ar_rd_req_mapper_pkg::*;
#(
  parameter int MRRS_BYTES = 512
) (
  input  logic [11:0] i_addr_lo,     // cur_addr[11:0]; MRRS <= 4 KB
  input  logic [15:0] i_remaining,   // bytes still to request, never 0 here
  output logic [12:0] o_seg_bytes,
  output logic [9:0]  o_len_dw,      // 1024 DW encodes as 0
  output logic [3:0]  o_first_be,
  output logic [3:0]  o_last_be,
  output logic        o_last_seg
);

  localparam logic [12:0] MRRS      = 13'(MRRS_BYTES);
  localparam logic [11:0] MRRS_MASK = 12'(MRRS_BYTES - 1);

  logic [12:0] w_room;
  logic [12:0] w_seg;
  logic [13:0] w_dw_count;
  logic [1:0]  w_end_off;
  logic [7:0]  w_be;

  // Segment stops at whichever comes first: end of burst or MRRS boundary
  always_comb begin
    w_room     = MRRS - {1'b0, i_addr_lo & MRRS_MASK};
    w_seg      = ({3'd0, w_room} < i_remaining) ? w_room : i_remaining[12:0];
    w_dw_count = ({12'd0, i_addr_lo[1:0]} + {1'b0, w_seg} + 14'd3) >> 2;
    w_end_off  = i_addr_lo[1:0] + w_seg[1:0] - 2'd1;
    w_be       = first_last_be(i_addr_lo[1:0], w_end_off, (w_dw_count == 14'd1));
  end

  assign o_seg_bytes = w_seg;
  assign o_len_dw    = w_dw_count[9:0];
  assign o_first_be  = w_be[3:0];
  assign o_last_be   = w_be[7:4];
  assign o_last_seg  = ({3'd0, w_seg} == i_remaining);

endmodule

// File: rtl/ar_rd_req_mapper.sv
// Turns one popped AR FIFO entry into a sequence of PCIe MRd headers split
// on MRRS boundaries, hands them to the TX arbiter one at a time and
// returns the pop grant once the final segment is accepted.
module ar_rd_req_mapper
  import ar_rd_req_mapper_pkg::*;
#(
  parameter logic [15:0] REQUESTER_ID = 16'h0100,
  parameter int          MRRS_BYTES   = 512,
  parameter int          TAG_WIDTH    = DEF_TAG_WIDTH,
  parameter int          ID_WIDTH     = DEF_ID_WIDTH
) (
  input  logic                    CLK,
  input  logic                    ARESTn,
  ar_rd_req_mapper_if.slave       bus,
  output rd_map_state_e           dbg_state
);

  rd_map_state_e        r_state;
  rd_map_state_e        w_next;

  // captured entry
  logic [63:0]          r_ar_addr;
  logic [7:0]           r_ar_len;
  logic [2:0]           r_ar_size;
  logic [1:0]           r_ar_burst;
  logic [ID_WIDTH-1:0]  r_id;
  logic                 r_local;

  // segmentation progress and presented header
  logic [15:0]          r_remaining;
  logic [63:0]          r_cur_addr;
  logic [TAG_WIDTH-1:0] r_tag;
  logic [127:0]         r_hdr;
  logic [12:0]          r_seg_bytes;
  logic                 r_last;

  logic                 w_req;
  logic                 w_pop;
  logic [15:0]          w_beats;
  logic [15:0]          w_cap_remaining;
  logic [63:0]          w_wrap_mask;
  logic [63:0]          w_cap_addr;
  logic [2:0]           w_fmt;
  logic [31:0]          w_dw0;
  logic [31:0]          w_dw1;
  logic [31:0]          w_dw2;
  logic [31:0]          w_dw3;

  logic [12:0]          w_seg_bytes;
  logic [9:0]           w_len_dw;
  logic [3:0]           w_first_be;
  logic [3:0]           w_last_be;
  logic                 w_last_seg;

  mrd_seg_calc #(
    .MRRS_BYTES (MRRS_BYTES)
  ) u_seg_calc (
    .i_addr_lo   (r_cur_addr[11:0]),
    .i_remaining (r_remaining),
    .o_seg_bytes (w_seg_bytes),
    .o_len_dw    (w_len_dw),
    .o_first_be  (w_first_be),
    .o_last_be   (w_last_be),
    .o_last_seg  (w_last_seg)
  );

  // Burst byte count and start address; WRAP reads the whole aligned container
  always_comb begin
    w_beats         = {8'd0, r_ar_len} + 16'd1;
    w_cap_remaining = (r_ar_burst == BURST_FIXED) ? (16'd1 << r_ar_size)
                                                  : (w_beats << r_ar_size);
    w_wrap_mask     = {48'd0, w_cap_remaining - 16'd1};
    w_cap_addr      = (r_ar_burst == BURST_WRAP) ? (r_ar_addr & ~w_wrap_mask)
                                                 : r_ar_addr;
  end

  // MRd header for the current segment; DW0 sits in tlp_hdr[127:96]
  always_comb begin
    w_fmt = (r_cur_addr[63:32] == 32'd0) ? MRD_FMT_3DW : MRD_FMT_4DW;
    // TC, Attr, TH, TD, EP, AT and reserved bits are all zero
    w_dw0 = {w_fmt, MRD_TYPE, 14'd0, w_len_dw};
    w_dw1 = {REQUESTER_ID, 8'(r_tag), w_last_be, w_first_be};
    if (w_fmt == MRD_FMT_3DW) begin
      w_dw2 = {r_cur_addr[31:2], 2'b00};
      w_dw3 = 32'd0;
    end else begin
      w_dw2 = r_cur_addr[63:32];
      w_dw3 = {r_cur_addr[31:2], 2'b00};
    end
  end

  // State register
  always_ff @(posedge CLK or negedge ARESTn) begin
    if (!ARESTn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state plus request/pop-grant decode
  always_comb begin
    w_next = r_state;
    w_req  = 1'b0;
    w_pop  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.rd_atop_en) w_next = CAPTURE;
      end
      CAPTURE: begin
        w_next = r_local ? LOCAL : CALC;
      end
      CALC: begin
        w_next = REQ;
      end
      REQ: begin
        w_req = 1'b1;
        if (bus.arb_rd_grant) begin
          if (r_last) begin
            w_pop  = 1'b1;
            w_next = IDLE;
          end else begin
            w_next = CALC;
          end
        end
      end
      LOCAL: begin
        w_pop  = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Entry capture, segment bookkeeping and header registration
  always_ff @(posedge CLK or negedge ARESTn) begin
    if (!ARESTn) begin
      r_ar_addr   <= '0;
      r_ar_len    <= '0;
      r_ar_size   <= '0;
      r_ar_burst  <= '0;
      r_id        <= '0;
      r_local     <= 1'b0;
      r_remaining <= '0;
      r_cur_addr  <= '0;
      r_tag       <= '0;
      r_hdr       <= '0;
      r_seg_bytes <= '0;
      r_last      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.rd_atop_en) begin
            r_ar_addr  <= bus.ar_addr;
            r_ar_len   <= bus.ar_len;
            r_ar_size  <= bus.ar_size;
            r_ar_burst <= bus.ar_burst;
            r_id       <= bus.ar_id;
            r_local    <= (bus.ar_user[2:0] == USER_LOCAL);
          end
        end
        CAPTURE: begin
          r_remaining <= w_cap_remaining;
          r_cur_addr  <= w_cap_addr;
        end
        CALC: begin
          r_hdr       <= {w_dw0, w_dw1, w_dw2, w_dw3};
          r_seg_bytes <= w_seg_bytes;
          r_last      <= w_last_seg;
        end
        REQ: begin
          if (bus.arb_rd_grant) begin
            r_tag       <= r_tag + 1'b1;
            r_remaining <= r_remaining - {3'd0, r_seg_bytes};
            r_cur_addr  <= r_cur_addr + {51'd0, r_seg_bytes};
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.tlp_rd_req       = w_req;
  assign bus.axi_req_rd_grant = w_pop;
  assign bus.tlp_hdr          = r_hdr;
  assign bus.tlp_tag          = r_tag;
  assign bus.trk_id           = r_id;
  assign bus.trk_last         = r_last;
  assign bus.trk_seg_bytes    = r_seg_bytes;
  assign dbg_state            = r_state;

endmodule

// File: tb/tb_ar_rd_req_mapper.sv
// Bench for ar_rd_req_mapper: directed entries from the test plan followed
// by random AR entries, checked against a byte-level segmentation model.
module tb_ar_rd_req_mapper;
  import ar_rd_req_mapper_pkg::*;

  localparam int          IDW    = DEF_ID_WIDTH;
  localparam int          TAGW   = 8;
  localparam int          USERW  = DEF_ARUSER_WIDTH;
  localparam int          MRRS   = 512;
  localparam logic [15:0] REQ_ID = 16'h0100;

  typedef struct packed {
    logic            is_local;
    logic            last;
    logic [12:0]     seg;
    logic [IDW-1:0]  id;
    logic [7:0]      tag;
    logic [127:0]    hdr;
  } exp_t;

  localparam int W = $bits(exp_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic arestn = 1'b0;
  always #5 clk = ~clk;

  ar_rd_req_mapper_if #(.ID_WIDTH(IDW), .TAG_WIDTH(TAGW), .ARUSER_WIDTH(USERW)) bus ();
  rd_map_state_e dbg_state;

  ar_rd_req_mapper #(
    .REQUESTER_ID (REQ_ID),
    .MRRS_BYTES   (MRRS),
    .TAG_WIDTH    (TAGW),
    .ID_WIDTH     (IDW)
  ) dut (
    .CLK       (clk),
    .ARESTn    (arestn),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int m_tag = 0;
  int grant_mode = 0;   // 0: random arbiter, 1: arbiter never grants

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference model: walks the burst byte range, cutting at MRRS multiples
  task automatic model_push(input logic [63:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input logic [IDW-1:0] id, input logic [USERW-1:0] user);
    logic [63:0] total_b, a, rem, seg, room;
    int len_dw, fl, el;
    logic [3:0] fbe, lbe;
    logic [2:0] fmt;
    logic [31:0] dw0, dw1, dw2, dw3;
    exp_t e;
    if (user[2:0] == 3'b011) begin
      e = '0;
      e.is_local = 1'b1;
      exp_q.push_back(W'(e));
      return;
    end
    total_b = (burst == 2'b00) ? (64'd1 << size) : ((64'(len) + 64'd1) << size);
    a = (burst == 2'b10) ? (addr - (addr % total_b)) : addr;
    rem = total_b;
    while (rem > 0) begin
      room = 64'(MRRS) - (a % 64'(MRRS));
      seg = (rem < room) ? rem : room;
      len_dw = int'(((a % 4) + seg + 3) / 4);
      fl = int'(a % 4);
      el = int'((a + seg - 1) % 4);
      for (int l = 0; l < 4; l++) begin
        fbe[l] = (l >= fl) && ((len_dw > 1) || (l <= el));
        lbe[l] = (len_dw > 1) && (l <= el);
      end
      fmt = ((a >> 32) != 0) ? 3'b001 : 3'b000;
      dw0 = {fmt, 5'b00000, 14'd0, 10'(len_dw % 1024)};
      dw1 = {REQ_ID, 8'(m_tag), lbe, fbe};
      if (fmt == 3'b000) begin
        dw2 = {a[31:2], 2'b00};
        dw3 = 32'd0;
      end else begin
        dw2 = a[63:32];
        dw3 = {a[31:2], 2'b00};
      end
      e.is_local = 1'b0;
      e.last = (rem == seg);
      e.seg = 13'(seg);
      e.id = id;
      e.tag = 8'(m_tag);
      e.hdr = {dw0, dw1, dw2, dw3};
      exp_q.push_back(W'(e));
      m_tag = (m_tag + 1) % 256;
      a = a + seg;
      rem = rem - seg;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic offer(input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size,
                       input logic [1:0] burst, input logic [IDW-1:0] id, input logic [USERW-1:0] user);
    model_push(addr, len, size, burst, id, user);
    bus.ar_addr = addr;
    bus.ar_len = len;
    bus.ar_size = size;
    bus.ar_burst = burst;
    bus.ar_id = id;
    bus.ar_user = user;
    bus.rd_atop_en = 1'b1;
  endtask

  task automatic finish_entry(input bit is_local);
    int n;
    bit seen_req, done;
    n = 0;
    seen_req = 0;
    done = 0;
    while (!done && n < 3000) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (!is_local && !seen_req && bus.tlp_rd_req) begin
        seen_req = 1;
        chk("first_req_latency", 128'(n), 128'd3);
      end
      if (bus.axi_req_rd_grant) begin
        done = 1;
        if (is_local) chk("local_pop_latency", 128'(n), 128'd2);
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL entry_timeout: no pop grant after %0d cycles", n);
    end
    @(posedge clk);
    #1;
    bus.rd_atop_en = 1'b0;
  endtask

  task automatic run_entry(input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [IDW-1:0] id, input logic [USERW-1:0] user);
    @(posedge clk);
    #1;
    offer(addr, len, size, burst, id, user);
    finish_entry(user[2:0] == 3'b011);
  endtask

  task automatic check_reset_outputs(input string tagname);
    chk({tagname, "_req"}, 128'(bus.tlp_rd_req), 128'd0);
    chk({tagname, "_pop"}, 128'(bus.axi_req_rd_grant), 128'd0);
    chk({tagname, "_hdr"}, bus.tlp_hdr, 128'd0);
    chk({tagname, "_tag"}, 128'(bus.tlp_tag), 128'd0);
    chk({tagname, "_trk"}, {bus.trk_id, bus.trk_last, bus.trk_seg_bytes}, 128'd0);
    chk({tagname, "_state"}, 128'(dbg_state), 128'(IDLE));
  endtask

  // ---------------- arbiter ----------------
  initial begin
    bus.arb_rd_grant = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.arb_rd_grant = (grant_mode == 0) ? ($urandom_range(0, 99) < 60) : 1'b0;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (arestn && (bus.tlp_rd_req || bus.axi_req_rd_grant)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", {126'd0, bus.tlp_rd_req, bus.axi_req_rd_grant}, 128'd0);
      end else begin
        e = exp_t'(exp_q[0]);
        if (e.is_local) begin
          chk("local_no_tlp", 128'(bus.tlp_rd_req), 128'd0);
          chk("local_pop", 128'(bus.axi_req_rd_grant), 128'd1);
          void'(exp_q.pop_front());
        end else begin
          chk("tlp_req", 128'(bus.tlp_rd_req), 128'd1);
          chk("tlp_hdr", bus.tlp_hdr, e.hdr);
          chk("tlp_tag", 128'(bus.tlp_tag), 128'(e.tag));
          chk("trk_id", 128'(bus.trk_id), 128'(e.id));
          chk("trk_last", 128'(bus.trk_last), 128'(e.last));
          chk("trk_seg_bytes", 128'(bus.trk_seg_bytes), 128'(e.seg));
          chk("pop_grant", 128'(bus.axi_req_rd_grant), 128'(bus.arb_rd_grant && e.last));
          if (bus.arb_rd_grant) void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int wl[4];
    logic [63:0] addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic [USERW-1:0] user;
    exp_t e;
    int n;

    wl = '{1, 3, 7, 15};
    bus.rd_atop_en = 1'b0;
    bus.ar_addr = '0;
    bus.ar_len = '0;
    bus.ar_size = '0;
    bus.ar_burst = '0;
    bus.ar_id = '0;
    bus.ar_user = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    arestn = 1'b1;

    // single 3DW TLP, 16 bytes
    run_entry(64'h1000, 8'd3, 3'd2, BURST_INCR, 4'(3), '0);
    // crosses a 512 B boundary after 4 bytes
    run_entry(64'h1FC, 8'd1, 3'd3, BURST_INCR, 4'(5), '0);
    // 4DW header, single byte at offset 2
    run_entry(64'h1_0000_0002, 8'd0, 3'd0, BURST_INCR, 4'(9), '0);

    // arbiter stalls, then reset lands mid-burst
    grant_mode = 1;
    @(posedge clk);
    #1;
    offer(64'h0, 8'd255, 3'd3, BURST_INCR, 4'(7), '0);
    n = 0;
    while (!bus.tlp_rd_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    e = exp_t'(exp_q[0]);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_req", 128'(bus.tlp_rd_req), 128'd1);
      chk("stall_hdr", bus.tlp_hdr, e.hdr);
      chk("stall_no_pop", 128'(bus.axi_req_rd_grant), 128'd0);
    end
    #2;
    arestn = 1'b0;
    exp_q.delete();
    m_tag = 0;
    bus.rd_atop_en = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    arestn = 1'b1;
    grant_mode = 0;

    // four MRRS-sized TLPs, tags 0..3
    run_entry(64'h0, 8'd255, 3'd3, BURST_INCR, 4'(2), '0);
    // locally completed entry
    run_entry(64'h2000, 8'd7, 3'd2, BURST_INCR, 4'(1), 4'b1011);
    // FIXED and WRAP spot checks
    run_entry(64'h3006, 8'd15, 3'd1, BURST_FIXED, 4'(4), '0);
    run_entry(64'h41F8, 8'd15, 3'd3, BURST_WRAP, 4'(6), '0);

    for (int k = 0; k < 40; k++) begin
      addr = {($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'd0, 32'($urandom)};
      burst = 2'($urandom_range(0, 2));
      size = 3'($urandom_range(0, 3));
      len = (burst == BURST_WRAP) ? 8'(wl[$urandom_range(0, 3)]) : 8'($urandom_range(0, 255));
      user = ($urandom_range(0, 7) == 0) ? USERW'(3) : USERW'($urandom_range(0, 15));
      run_entry(addr, len, size, burst, IDW'($urandom_range(0, 15)), user);
    end

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("queue_drained", 128'(exp_q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
